// File: rtl/mem_ctrl_sweep.sv
// rtl/mem_ctrl_sweep.sv - word-addressed memory with valid/ready requests, fixed-latency responses and post-reset clear sweep
//
// Ports:
//   clk        in   1          clock, all state on rising edge
//   reset      in   1          synchronous, active-high
//   req_valid  in   1          request present
//   req_ready  out  1          request accepted this cycle when req_valid is high
//   req_write  in   1          1 = write, 0 = read
//   req_wide   in   1          1 = two-word access (low word at addr, high at addr+1)
//   req_addr   in   ADDR_W     word address
//   req_wdata  in   2*DATA_W   write data, narrow uses the low word
//   rsp_valid  out  1          one-cycle pulse per accepted request, in order
//   rsp_rdata  out  2*DATA_W   read data (narrow zero-extended), 0 otherwise
//   rsp_err    out  1          out-of-range access, 0 when rsp_valid is low
//   init_busy  out  1          clear sweep in progress

module mem_ctrl_sweep #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] WIDE2 = 2'd2;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [1:0]          r_state;
  logic [PTR_W-1:0]    r_ptr;

  // Second-beat context captured when a wide request is accepted, so the
  // requester is free to change its inputs during WIDE2.
  logic                r_write;
  logic                r_err;
  logic [PTR_W-1:0]    r_hi_addr;
  logic [DATA_W-1:0]   r_wdata_hi;
  logic [DATA_W-1:0]   r_lo_rdata;

  // Response pipeline: stage 0 is loaded on the final beat, the last stage
  // drives the outputs, giving exactly RD_LAT cycles of latency.
  logic                r_pv [RD_LAT];
  logic [2*DATA_W-1:0] r_pd [RD_LAT];
  logic                r_pe [RD_LAT];

  logic                w_accept;
  logic                w_narrow_err;
  logic                w_wide_err;
  logic                w_err;
  logic [PTR_W-1:0]    w_idx;
  logic [PTR_W-1:0]    w_raddr;
  logic [DATA_W-1:0]   w_rword;

  logic                w_we;
  logic [PTR_W-1:0]    w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  logic                w_fin_valid;
  logic                w_fin_err;
  logic [2*DATA_W-1:0] w_fin_data;

  assign req_ready = (r_state == IDLE);
  assign init_busy = (r_state == INIT);
  assign w_accept  = req_valid && (r_state == IDLE);

  // No wrap: a wide access needs both addr and addr+1 inside the array.
  assign w_narrow_err = (req_addr >= ADDR_W'(DEPTH));
  assign w_wide_err   = (req_addr >= ADDR_W'(DEPTH - 1));
  assign w_err        = req_wide ? w_wide_err : w_narrow_err;
  assign w_idx        = req_addr[PTR_W-1:0];

  // Single read port: request address in IDLE, captured high address in WIDE2.
  assign w_raddr = (r_state == WIDE2) ? r_hi_addr : w_idx;
  assign w_rword = r_mem[w_raddr];

  // Single write port shared by the sweep, narrow/low-beat writes and the
  // high beat. An errored access writes neither half.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = '0;
    if (!reset) begin
      case (r_state)
        INIT: begin
          w_we    = 1'b1;
          w_waddr = r_ptr;
        end
        IDLE: begin
          if (w_accept && req_write && !w_err) begin
            w_we    = 1'b1;
            w_waddr = w_idx;
            w_wdata = req_wdata[DATA_W-1:0];
          end
        end
        WIDE2: begin
          if (r_write && !r_err) begin
            w_we    = 1'b1;
            w_waddr = r_hi_addr;
            w_wdata = r_wdata_hi;
          end
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Final beat of each request feeds the response pipeline. Read data is only
  // non-zero for successful reads, keeping rsp_rdata 0 for writes and errors.
  always_comb begin
    w_fin_valid = 1'b0;
    w_fin_err   = 1'b0;
    w_fin_data  = '0;
    if (r_state == IDLE && w_accept && !req_wide) begin
      w_fin_valid = 1'b1;
      w_fin_err   = w_err;
      if (!w_err && !req_write) begin
        w_fin_data = {{DATA_W{1'b0}}, w_rword};
      end
    end else if (r_state == WIDE2) begin
      w_fin_valid = 1'b1;
      w_fin_err   = r_err;
      if (!r_err && !r_write) begin
        w_fin_data = {w_rword, r_lo_rdata};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_ptr      <= '0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_hi_addr  <= '0;
      r_wdata_hi <= '0;
      r_lo_rdata <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_ptr <= r_ptr + PTR_W'(1);
          if (r_ptr == PTR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_accept && req_wide) begin
            r_state    <= WIDE2;
            r_write    <= req_write;
            r_err      <= w_err;
            r_hi_addr  <= w_idx + PTR_W'(1);
            r_wdata_hi <= req_wdata[2*DATA_W-1:DATA_W];
            r_lo_rdata <= w_rword;
          end
        end
        WIDE2: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= INIT;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Reset flushes every stage, so in-flight responses are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pe[i] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_fin_valid;
      r_pd[0] <= w_fin_data;
      r_pe[0] <= w_fin_err;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  assign rsp_valid = r_pv[RD_LAT-1];
  assign rsp_rdata = r_pd[RD_LAT-1];
  assign rsp_err   = r_pe[RD_LAT-1];

endmodule

// File: tb/tb_mem_ctrl_sweep.sv
// tb/tb_mem_ctrl_sweep.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=3 instances with one stimulus stream

module tb_mem_ctrl_sweep;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        req_wide;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        ready1, rsp_valid1, rsp_err1, busy1;
  logic [31:0] rsp_rdata1;
  logic        ready3, rsp_valid3, rsp_err3, busy3;
  logic [31:0] rsp_rdata3;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [15:0] mdl [0:15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_sweep #(.DATA_W(16), .DEPTH(16), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_write(req_write), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .init_busy(busy1)
  );

  mem_ctrl_sweep #(.DATA_W(16), .DEPTH(16), .ADDR_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
    .req_write(req_write), .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .init_busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d, input logic e);
    exp_t  x;
    string p;
    p = (k == 0) ? "lat1" : "lat3";
    if (v) begin
      if ((k == 0 && q1.size() == 0) || (k == 1 && q3.size() == 0)) begin
        check({p, " rsp_unexpected"}, {31'b0, v}, 32'd0);
      end else begin
        if (k == 0) x = q1.pop_front();
        else        x = q3.pop_front();
        check({p, " rsp_cycle"}, 32'(cyc), 32'(x.c));
        check({p, " rsp_rdata"}, d, x.d);
        check({p, " rsp_err"}, {31'b0, e}, {31'b0, x.e});
      end
    end else begin
      check({p, " idle_rdata"}, d, 32'd0);
      check({p, " idle_err"}, {31'b0, e}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, rsp_valid1, rsp_rdata1, rsp_err1);
      mon(1, rsp_valid3, rsp_rdata3, rsp_err3);
    end
  end

  // Drive one request, wait (bounded) for acceptance, push expectations,
  // then scramble the fields to show the controller captured them.
  task automatic req(input logic w, input logic wide, input logic [31:0] a, input logic [31:0] wd);
    exp_t x;
    int   waitc;
    logic err;
    waitc     = 0;
    req_valid = 1'b1;
    req_write = w;
    req_wide  = wide;
    req_addr  = a;
    req_wdata = wd;
    while (!ready1 && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!ready1) begin
      check("req_ready_timeout", {31'b0, ready1}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    err = wide ? (a >= 32'd15) : (a >= 32'd16);
    x.e = err;
    x.d = 32'd0;
    if (!err) begin
      if (w) begin
        mdl[a[3:0]] = wd[15:0];
        if (wide) mdl[a[3:0] + 4'd1] = wd[31:16];
      end else begin
        x.d = wide ? {mdl[a[3:0] + 4'd1], mdl[a[3:0]]} : {16'd0, mdl[a[3:0]]};
      end
    end
    x.c = cyc + 1 + (wide ? 1 : 0);
    q1.push_back(x);
    x.c = cyc + 3 + (wide ? 1 : 0);
    q3.push_back(x);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_wide  = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, " init_busy"}, {30'b0, busy1, busy3}, 32'd3);
      check({tag, " ready_low"}, {30'b0, ready1, ready3}, 32'd0);
      @(posedge clk); #1;
    end
    check({tag, " init_done"}, {30'b0, busy1, busy3}, 32'd0);
    check({tag, " ready_high"}, {30'b0, ready1, ready3}, 32'd3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;

    // 1: one-cycle reset, 16-cycle sweep, then memory reads as zero
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset rsp_valid", {30'b0, rsp_valid1, rsp_valid3}, 32'd0);
    check_sweep("sweep1");
    req(1'b0, 1'b0, 32'd3, 32'd0);

    // 2: write then read-after-write back to back
    req(1'b1, 1'b0, 32'd5, 32'h0000BEEF);
    req(1'b0, 1'b0, 32'd5, 32'd0);

    // 3: wide write stalls for one cycle, wide read returns both words
    req(1'b1, 1'b1, 32'd8, 32'h12345678);
    check("wide2 ready_low", {30'b0, ready1, ready3}, 32'd0);
    req(1'b0, 1'b1, 32'd8, 32'd0);
    req(1'b0, 1'b0, 32'd9, 32'd0);

    // 4: range errors leave memory untouched
    req(1'b1, 1'b0, 32'd15, 32'h00001111);
    req(1'b1, 1'b1, 32'd15, 32'hAAAA5555);
    req(1'b0, 1'b0, 32'd15, 32'd0);
    req(1'b0, 1'b0, 32'd16, 32'd0);
    req(1'b0, 1'b1, 32'd14, 32'd0);
    req(1'b0, 1'b0, 32'h8000_0003, 32'd0);

    // 5: full-throughput narrow reads, in-order responses
    req(1'b1, 1'b0, 32'd1, 32'h0000A001);
    req(1'b1, 1'b0, 32'd2, 32'h0000A002);
    req(1'b1, 1'b0, 32'd4, 32'h0000A004);
    req(1'b0, 1'b0, 32'd1, 32'd0);
    req(1'b0, 1'b0, 32'd2, 32'd0);
    req(1'b0, 1'b0, 32'd3, 32'd0);
    req(1'b0, 1'b0, 32'd4, 32'd0);
    idle(6);
    check("drain1 q1_empty", 32'(q1.size()), 32'd0);
    check("drain1 q3_empty", 32'(q3.size()), 32'd0);

    // 6: reset during WIDE2 aborts the request and re-clears memory
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wide  = 1'b1;
    req_addr  = 32'd8;
    req_wdata = 32'hCAFED00D;
    check("abort accept_ready", {30'b0, ready1, ready3}, 32'd3);
    @(posedge clk); #1;
    check("abort in_wide2", {30'b0, ready1, ready3}, 32'd0);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    check_sweep("sweep2");
    req(1'b0, 1'b0, 32'd8, 32'd0);
    req(1'b0, 1'b0, 32'd9, 32'd0);
    req(1'b0, 1'b1, 32'd4, 32'd0);
    idle(8);
    check("final q1_empty", 32'(q1.size()), 32'd0);
    check("final q3_empty", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
